serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 27 ++
 rtl/serial_add_ctrl_add4_slice.sv | 27 ++
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding,
// nibble width and the basic half/full adder cells.
package serial_add_ctrl_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Half adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Full adder cell built from two half adders: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_add(a, b);
        h2 = half_add(h1[0], ci);
        return {h1[1] | h2[1], h2[0]};
    endfunction

endpackage

// File: rtl/serial_add_ctrl_add4_slice.sv
// Purely combinational 4-bit ripple-carry slice. Bit 0 is a full cell so the
// registered carry can enter; the upper bits are full cells because the
// ripple carry arrives at each of them.
module add4_slice
    import serial_add_ctrl_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           ci,
    output logic [NIB-1:0] s,
    output logic           c
);

    logic [NIB:0] cy;

    // Ripple the carry from bit 0 upwards.
    always_comb begin
        cy    = '0;
        s     = '0;
        cy[0] = ci;
        for (int i = 0; i < NIB; i++) begin
            {cy[i+1], s[i]} = full_add(a[i], b[i], cy[i]);
        end
        c = cy[NIB];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder: one 4-bit slice is time-shared over WORDS nibbles, LSB
// nibble first, with the carry registered between nibbles.
//
// Handshake: start is sampled only while busy=0 (IDLE); a sampled start is the
// acceptance and captures ain/bin/cin. busy is high from the cycle after
// acceptance through the done cycle. done pulses for one cycle with so/co
// valid; so/co then hold until the next acceptance clears them.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int N     = NIB * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] ain,
    input  logic [N-1:0] bin,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] so,
    output logic         co,
    output state_e       dbg_state_o
);

    localparam int              IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            c_q, c_d;
    logic [N-1:0]    so_q, so_d;
    logic            co_q, co_d;

    logic            accept;
    logic            last;
    logic [NIB-1:0]  a_nib;
    logic [NIB-1:0]  b_nib;
    logic [NIB-1:0]  s_nib;
    logic            c_nib;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (idx_q == LAST);

    // Nibble select feeding the shared slice.
    assign a_nib = a_q[NIB*int'(idx_q) +: NIB];
    assign b_nib = b_q[NIB*int'(idx_q) +: NIB];

    add4_slice u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (c_q),
        .s  (s_nib),
        .c  (c_nib)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            so_q    <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            so_q    <= so_d;
            co_q    <= co_d;
        end
    end

    // Next state: IDLE -> RUN on start, RUN -> DONE after the top nibble, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on acceptance, then one nibble written back per RUN cycle.
    always_comb begin
        idx_d = idx_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        so_d  = so_q;
        co_d  = co_q;
        if (accept) begin
            a_d   = ain;
            b_d   = bin;
            c_d   = cin;
            idx_d = '0;
            so_d  = '0;
            co_d  = 1'b0;
        end else if (state_q == RUN) begin
            so_d[NIB*int'(idx_q) +: NIB] = s_nib;
            c_d = c_nib;
            if (last) begin
                co_d = c_nib;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign so          = so_q;
    assign co          = co_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a cycle-level model of the start/busy/done
// protocol with an expected-sum queue, plus directed vectors with literal sums.
module tb_serial_add_ctrl;
    import serial_add_ctrl_pkg::*;

    localparam int WORDS = 4;
    localparam int N     = 4 * WORDS;

    // ---------------- clock / reset ----------------
    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [N-1:0] ain   = '0;
    logic [N-1:0] bin   = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] so;
    logic         co;
    state_e       dbg_state;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ain         (ain),
        .bin         (bin),
        .cin         (cin),
        .busy        (busy),
        .done        (done),
        .so          (so),
        .co          (co),
        .dbg_state_o (dbg_state)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    // phase = cycles since acceptance (0 = idle). Busy for phases 1..WORDS+1,
    // result due at phase WORDS+1, and {co,so} = ain + bin + cin exactly.
    int           phase = 0;
    logic [N:0]   held  = '0;
    logic [N:0]   exp_q[$];
    logic [N:0]   e_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            held  = '0;
            exp_q.delete();
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                exp_q.push_back({1'b0, ain} + {1'b0, bin} + {{N{1'b0}}, cin});
            end
        end else if (phase == WORDS + 1) begin
            phase = 0;
        end else begin
            phase++;
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, phase != 0});
        check("done", {31'd0, done}, {31'd0, phase == WORDS + 1});
        if (phase == WORDS + 1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sum: done cycle with empty expected queue at %0t", $time);
            end else begin
                e_sum = exp_q.pop_front();
                check("sum", {15'd0, co, so}, {15'd0, e_sum});
                held = e_sum;
            end
        end else if (phase == 0) begin
            check("held", {15'd0, co, so}, {15'd0, held});
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge in IDLE; returns at the negedge of the idle cycle after done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input logic [N-1:0] exp_so, input logic exp_co, input string name);
        int k;
        bit seen;
        ain   = a;
        bin   = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        seen  = 1'b0;
        while (!seen && k <= 20) begin
            if (done) begin
                seen = 1'b1;
                check({name, " latency"}, k, WORDS + 1);
                check({name, " so"}, {16'd0, so}, {16'd0, exp_so});
                check({name, " co"}, {31'd0, co}, {31'd0, exp_co});
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s timeout: no done within 20 cycles", name);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ndone;

        // Reset then idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle busy", {31'd0, busy}, 32'd0);
        check("idle so", {16'd0, so}, 32'd0);
        check("idle co", {31'd0, co}, 32'd0);

        // Carry through every nibble, carry-in, mixed values, top-bit overflow.
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "mixed");
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb");
        check("hold so", {16'd0, so}, 32'd0);
        check("hold co", {31'd0, co}, 32'd1);

        // Start while busy is ignored.
        ain = 16'h0001; bin = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;                          // cycle 1
        @(negedge clk); ain = 16'hAAAA; bin = 16'h5555; start = 1'b1; // cycle 2
        @(negedge clk); start = 1'b0;                          // cycle 3
        @(negedge clk);                                        // cycle 4
        @(negedge clk);                                        // cycle 5
        check("busy-start done", {31'd0, done}, 32'd1);
        check("busy-start so", {16'd0, so}, 32'h0002);
        @(negedge clk);                                        // cycle 6
        check("busy-start busy fall", {31'd0, busy}, 32'd0);
        check("busy-start single done", {31'd0, done}, 32'd0);

        // Back-to-back with start held; ain changes mid-RUN.
        ain = 16'h0F0F; bin = 16'h0101; cin = 1'b0; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) ain = 16'h7000;
            if (k == 7) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("b2b first cycle", k, 5);
                    check("b2b first so", {16'd0, so}, 32'h1010);
                end else begin
                    check("b2b second cycle", k, 11);
                    check("b2b second so", {16'd0, so}, 32'h7101);
                end
            end
        end
        check("b2b done count", ndone, 2);

        // Reset mid-operation.
        ain = 16'h1111; bin = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort so", {16'd0, so}, 32'd0);
        check("abort co", {31'd0, co}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, "after-abort");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
